// File: rtl/lock_controller.sv
// lock_controller: sequencing FSM for unlock, lockout, auto-relock and two-entry password change.
module lock_controller #(
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 30_000_000,
    parameter int UNLOCK_CYCLES  = 100_000_000
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        confirm_pulse,
    input  logic        exit_pulse,
    input  logic        exit_hold_pulse,
    input  logic [15:0] value_16bit,
    input  logic [15:0] password,
    output logic        unlocked,
    output logic        set_mode,
    output logic        lockout,
    output logic [2:0]  fail_count,
    output logic        password_we,
    output logic [15:0] password_new,
    output logic        set_err
);
    localparam int MAXC = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
    localparam int TW = $clog2(MAXC + 1);
    localparam logic [TW-1:0] T_UNL = TW'(UNLOCK_CYCLES);
    localparam logic [TW-1:0] T_LCK = TW'(LOCKOUT_CYCLES);
    localparam logic [TW-1:0] T_ONE = TW'(1);

    typedef enum logic [2:0] {S_LOCKED, S_UNLOCKED, S_SET_NEW, S_SET_VERIFY, S_LOCKOUT} state_t;

    state_t      r_state, w_state;
    logic [TW-1:0] r_timer, w_timer;
    logic [2:0]  r_fail, w_fail, w_fail_inc;
    logic [15:0] r_cand, w_cand, r_pnew, w_pnew;
    logic        w_we, w_err;
    logic        r_unlocked, r_set_mode, r_lockout, r_we, r_err;

    assign w_fail_inc = (r_fail == 3'd7) ? r_fail : r_fail + 3'd1;

    always_comb begin
        w_state = r_state;
        w_timer = r_timer;
        w_fail  = r_fail;
        w_cand  = r_cand;
        w_pnew  = r_pnew;
        w_we    = 1'b0;
        w_err   = 1'b0;
        case (r_state)
            S_LOCKED: begin
                if (confirm_pulse) begin
                    if (value_16bit == password) begin
                        w_state = S_UNLOCKED;
                        w_fail  = 3'd0;
                        w_timer = T_UNL;
                    end else begin
                        w_fail = w_fail_inc;
                        if (w_fail_inc == 3'(MAX_FAILS)) begin
                            w_state = S_LOCKOUT;
                            w_timer = T_LCK;
                        end
                    end
                end
            end
            S_UNLOCKED: begin
                if (exit_hold_pulse) begin
                    w_state = S_SET_NEW;
                end else if (exit_pulse) begin
                    w_state = S_LOCKED;
                end else begin
                    w_timer = r_timer - T_ONE;
                    if (r_timer == T_ONE) w_state = S_LOCKED;
                end
            end
            S_SET_NEW, S_SET_VERIFY: begin
                if (exit_pulse) begin
                    w_state = S_UNLOCKED;
                    w_cand  = 16'h0000;
                    w_timer = T_UNL;
                end else if (confirm_pulse) begin
                    if (r_state == S_SET_NEW) begin
                        w_cand  = value_16bit;
                        w_state = S_SET_VERIFY;
                    end else if (value_16bit == r_cand) begin
                        w_we    = 1'b1;
                        w_pnew  = r_cand;
                        w_state = S_UNLOCKED;
                        w_timer = T_UNL;
                    end else begin
                        w_err   = 1'b1;
                        w_cand  = 16'h0000;
                        w_state = S_SET_NEW;
                    end
                end
            end
            S_LOCKOUT: begin
                w_timer = r_timer - T_ONE;
                if (r_timer == T_ONE) begin
                    w_state = S_LOCKED;
                    w_fail  = 3'd0;
                end
            end
            default: w_state = S_LOCKED;
        endcase
    end

    // status flags are registered from the next state so they change with it
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state    <= S_LOCKED;
            r_timer    <= '0;
            r_fail     <= 3'd0;
            r_cand     <= 16'h0000;
            r_pnew     <= 16'h0000;
            r_we       <= 1'b0;
            r_err      <= 1'b0;
            r_unlocked <= 1'b0;
            r_set_mode <= 1'b0;
            r_lockout  <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_timer    <= w_timer;
            r_fail     <= w_fail;
            r_cand     <= w_cand;
            r_pnew     <= w_pnew;
            r_we       <= w_we;
            r_err      <= w_err;
            r_unlocked <= (w_state == S_UNLOCKED);
            r_set_mode <= (w_state == S_SET_NEW) || (w_state == S_SET_VERIFY);
            r_lockout  <= (w_state == S_LOCKOUT);
        end
    end

    assign unlocked     = r_unlocked;
    assign set_mode     = r_set_mode;
    assign lockout      = r_lockout;
    assign fail_count   = r_fail;
    assign password_we  = r_we;
    assign password_new = r_pnew;
    assign set_err      = r_err;
endmodule

// File: doc/lock_controller.md
# lock_controller

Top-level sequencing FSM for the digital lock. It takes debounced single-cycle button events and the 16-bit entered code, and decides four things: unlock, failed-attempt counting and timed lockout, auto-relock, and the two-entry password-change procedure. It owns the write strobe to the password register, which holds the stored code and feeds it back on `password`. It sits between the button/keypad front end and the password register, and drives the status LEDs and display mode.

## Interface
- `MAX_FAILS`, default 3: consecutive wrong codes that trigger lockout; legal range 1..7.
- `LOCKOUT_CYCLES`, default 30_000_000: clock cycles spent in LOCKOUT; must be ≥1.
- `UNLOCK_CYCLES`, default 100_000_000: clock cycles UNLOCKED stays open before auto-relock; must be ≥1.
- `clk_in` input 1: system clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `confirm_pulse` input 1: one-cycle confirm event.
- `exit_pulse` input 1: one-cycle short-press exit event.
- `exit_hold_pulse` input 1: one-cycle event issued when exit is held 3 s.
- `value_16bit` input 16: currently entered code, 4 BCD digits.
- `password` input 16: stored code, read from the password register.
- `unlocked` output 1: high in UNLOCKED.
- `set_mode` output 1: high in SET_NEW and SET_VERIFY.
- `lockout` output 1: high in LOCKOUT; drives the alarm LED.
- `fail_count` output 3: consecutive wrong attempts.
- `password_we` output 1: one-cycle write strobe to the password register.
- `password_new` output 16: data for `password_we`.
- `set_err` output 1: one-cycle pulse when the verify entry mismatches.

## Operation
- **States:** LOCKED, UNLOCKED, SET_NEW, SET_VERIFY, LOCKOUT. Encoding is free.
- **Event priority in one cycle:** `exit_hold_pulse` > `exit_pulse` > `confirm_pulse`. Only the highest-priority event that is meaningful in the current state acts; the others are dropped.
- **LOCKED**
  - `confirm_pulse` with `value_16bit == password`: go to UNLOCKED, clear `fail_count`, load timer with UNLOCK_CYCLES.
  - `confirm_pulse` with a mismatch: increment `fail_count`. If the new count equals MAX_FAILS, go to LOCKOUT and load timer with LOCKOUT_CYCLES.
  - Exit events are ignored.
- **UNLOCKED**
  - Timer decrements every cycle; at expiry go to LOCKED.
  - `exit_pulse`: go to LOCKED immediately.
  - `exit_hold_pulse`: go to SET_NEW; timer is frozen.
  - `confirm_pulse` is ignored.
- **SET_NEW**
  - `confirm_pulse`: capture `value_16bit` into the candidate register, go to SET_VERIFY.
  - `exit_pulse`: go to UNLOCKED, discard the candidate, reload timer with UNLOCK_CYCLES.
- **SET_VERIFY**
  - `confirm_pulse` with `value_16bit == candidate`: pulse `password_we` with `password_new` = candidate, go to UNLOCKED, reload timer.
  - `confirm_pulse` with a mismatch: pulse `set_err`, go to SET_NEW, clear the candidate.
  - `exit_pulse`: same as in SET_NEW.
- **LOCKOUT**
  - All button inputs are ignored.
  - Timer decrements; at expiry go to LOCKED and clear `fail_count`.
- **Fail counter:** 3 bits, saturating, never wraps. It is only cleared by reset, a correct code, or the end of lockout.
- **Timer:** width is `$clog2(max(LOCKOUT_CYCLES, UNLOCK_CYCLES)+1)`, unsigned down-counter. Expiry means the registered value is 1 on a decrement cycle.
- **Equality compares:** full 16-bit; no digit masking.
- **`password` input:** sampled only on LOCKED confirm events. A change on `password` at any other time has no effect on state.

## Timing
- **Reset values:** state = LOCKED; `unlocked`, `set_mode`, `lockout`, `password_we`, `set_err` = 0; `fail_count` = 0; `password_new` = 16'h0000; candidate and timer = 0.
- **Registered outputs:** all outputs are registered. A state change, and the matching change on `unlocked`/`set_mode`/`lockout`, is visible on the cycle after the triggering pulse.
- **`password_we` and `set_err`:** high for exactly one cycle, the cycle after the SET_VERIFY confirm. `password_new` is valid in the same cycle and holds its value afterwards.
- **LOCKOUT duration:** `lockout` is high for exactly LOCKOUT_CYCLES cycles.
- **UNLOCKED duration:** `unlocked` is high for exactly UNLOCK_CYCLES cycles when no events arrive.
- **Back-to-back events:** accepted on consecutive cycles. No input is buffered; an event arriving during a state where it has no meaning is lost.
- **Reset mid-operation:** `rst` in any state returns to LOCKED on the next edge. It aborts a pending candidate and suppresses any `password_we` that same cycle.

## Test plan
Bench parameters: MAX_FAILS=3, LOCKOUT_CYCLES=20, UNLOCK_CYCLES=50.

1. `password`=16'h1234; confirm with `value_16bit`=16'h1234 → `unlocked`=1 one cycle later for exactly 50 cycles, then LOCKED; `fail_count` stays 0.
2. Three confirms with 16'h0000 while `password`=16'h1234 → `fail_count` reads 1, 2, 3; `lockout`=1 for exactly 20 cycles. Confirms during lockout are ignored. Afterwards `fail_count`=0 and a correct code unlocks.
3. Two wrong codes then the correct one → unlock, `fail_count` cleared to 0. A third wrong code after relock gives `fail_count`=1, no lockout.
4. Unlocked; `exit_hold_pulse` → `set_mode`=1. Confirm 16'h5678, confirm 16'h5678 → `password_we` one-cycle pulse with `password_new`=16'h5678; `unlocked`=1 with timer reloaded to 50.
5. In SET_VERIFY, confirm 16'h9999 after candidate 16'h5678 → `set_err` one-cycle pulse, back to SET_NEW, no `password_we`. Then `exit_pulse` → UNLOCKED, `password_new` unchanged.
6. `exit_pulse` and `confirm_pulse` in the same cycle in SET_NEW → exit wins, no capture. Assert `rst` during SET_VERIFY on a matching confirm → LOCKED, `password_we` stays 0.
